// File: rtl/pc_stack_if.sv
// Control/observation bundle between the execute sequencer, the fetch path
// and the program-counter / return-stack unit.
interface pc_stack_if #(
  parameter int PC_WIDTH    = 11,
  parameter int STACK_DEPTH = 2
);
  localparam int PAGE_BITS = PC_WIDTH - 9;
  localparam int LVL_W     = $clog2(STACK_DEPTH + 1);

  logic                 q1_en;
  logic                 cmd_valid;
  logic [2:0]           cmd;
  logic [8:0]           imm;
  logic [PAGE_BITS-1:0] page_sel;
  logic [7:0]           pcl_data;
  logic                 clear_err;
  logic [PC_WIDTH-1:0]  pc;
  logic                 flush;
  logic [LVL_W-1:0]     stack_level;
  logic                 stack_overflow;
  logic                 stack_underflow;

  // Sequencer / fetch side.
  modport master (
    output q1_en, cmd_valid, cmd, imm, page_sel, pcl_data, clear_err,
    input  pc, flush, stack_level, stack_overflow, stack_underflow
  );

  // Program-counter unit side.
  modport slave (
    input  q1_en, cmd_valid, cmd, imm, page_sel, pcl_data, clear_err,
    output pc, flush, stack_level, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Paged program counter with an N-deep circular return stack.
// A jump (GOTO/CALL/RETLW/PCL write) loads the target and holds it across
// the next Q1 so fetch resumes exactly at the target, with the in-flight
// instruction flushed. Stack level saturates; misuse raises sticky flags.
module pc_stack_unit #(
  parameter int                  PC_WIDTH    = 11,
  parameter int                  STACK_DEPTH = 2,
  parameter logic [PC_WIDTH-1:0] RESET_VEC   = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_stack_if.slave   bus
);

  localparam int PAGE_BITS = PC_WIDTH - 9;
  localparam int SP_W      = $clog2(STACK_DEPTH);
  localparam int LVL_W     = $clog2(STACK_DEPTH + 1);

  localparam logic [SP_W-1:0]  SP_LAST  = SP_W'(STACK_DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_GOTO   = 3'd1,
    CMD_CALL   = 3'd2,
    CMD_RETLW  = 3'd3,
    CMD_SKIP   = 3'd4,
    CMD_PCL_WR = 3'd5
  } cmd_e;

  // Architectural state
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_flush;
  logic                r_hold;
  logic [SP_W-1:0]     r_sp;
  logic [LVL_W-1:0]    r_level;
  logic                r_ovf;
  logic                r_udf;
  logic [PC_WIDTH-1:0] r_mem [STACK_DEPTH];

  // Next-state and helper nets
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic                w_flush_nxt;
  logic                w_hold_nxt;
  logic [SP_W-1:0]     w_sp_nxt;
  logic [LVL_W-1:0]    w_level_nxt;
  logic                w_ovf_nxt;
  logic                w_udf_nxt;
  logic                w_push;
  logic [SP_W-1:0]     w_sp_inc;
  logic [SP_W-1:0]     w_sp_dec;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_pop_data;
  logic [PC_WIDTH-1:0] w_call_tgt;
  logic [PC_WIDTH-1:0] w_goto_tgt;
  logic [PC_WIDTH-1:0] w_pcl_tgt;
  cmd_e                w_cmd;
  logic                w_cmd_act;

  // Stack pointer moves modulo STACK_DEPTH, which need not be a power of two.
  assign w_sp_inc   = (r_sp == SP_LAST) ? '0 : r_sp + SP_W'(1);
  assign w_sp_dec   = (r_sp == '0) ? SP_LAST : r_sp - SP_W'(1);
  assign w_pc_inc   = r_pc + PC_WIDTH'(1);
  assign w_pop_data = r_mem[w_sp_dec];

  // Jump targets: CALL and PCL writes can only reach the lower half of a page.
  assign w_goto_tgt = {bus.page_sel, bus.imm};
  assign w_call_tgt = {bus.page_sel, 1'b0, bus.imm[7:0]};
  assign w_pcl_tgt  = {bus.page_sel, 1'b0, bus.pcl_data};

  // Reserved opcodes decode as "no command" so a coincident Q1 still advances.
  assign w_cmd     = cmd_e'(bus.cmd);
  assign w_cmd_act = bus.cmd_valid &&
                     (w_cmd inside {CMD_GOTO, CMD_CALL, CMD_RETLW,
                                    CMD_SKIP, CMD_PCL_WR});

  // Next-state decode; a command always overrides a coincident Q1 strobe.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    w_pc_nxt    = r_pc;
    w_flush_nxt = r_flush;
    w_hold_nxt  = r_hold;
    w_sp_nxt    = r_sp;
    w_level_nxt = r_level;
    w_ovf_nxt   = r_ovf & ~bus.clear_err;
    w_udf_nxt   = r_udf & ~bus.clear_err;
    w_push      = 1'b0;

    if (w_cmd_act) begin
      case (w_cmd)
        CMD_GOTO: begin
          w_pc_nxt    = w_goto_tgt;
          w_hold_nxt  = 1'b1;
          w_flush_nxt = 1'b1;
        end
        CMD_CALL: begin
          w_push      = 1'b1;
          w_sp_nxt    = w_sp_inc;
          w_pc_nxt    = w_call_tgt;
          w_hold_nxt  = 1'b1;
          w_flush_nxt = 1'b1;
          // A full stack still pushes, overwriting the oldest return address.
          if (r_level == LVL_FULL) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_level_nxt = r_level + LVL_W'(1);
          end
        end
        CMD_RETLW: begin
          w_sp_nxt    = w_sp_dec;
          w_pc_nxt    = w_pop_data;
          w_hold_nxt  = 1'b1;
          w_flush_nxt = 1'b1;
          // An empty stack still pops the wrapped entry.
          if (r_level == '0) begin
            w_udf_nxt = 1'b1;
          end else begin
            w_level_nxt = r_level - LVL_W'(1);
          end
        end
        CMD_SKIP: begin
          w_flush_nxt = 1'b1;
        end
        CMD_PCL_WR: begin
          w_pc_nxt    = w_pcl_tgt;
          w_hold_nxt  = 1'b1;
          w_flush_nxt = 1'b1;
        end
        default: begin
        end
      endcase
    end else if (bus.q1_en) begin
      w_pc_nxt    = r_hold ? r_pc : w_pc_inc;
      w_hold_nxt  = 1'b0;
      w_flush_nxt = 1'b0;
    end
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_VEC;
      r_flush <= 1'b0;
      r_hold  <= 1'b0;
      r_sp    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values computed above.
      r_pc    <= w_pc_nxt;
      r_flush <= w_flush_nxt;
      r_hold  <= w_hold_nxt;
      r_sp    <= w_sp_nxt;
      r_level <= w_level_nxt;
      r_ovf   <= w_ovf_nxt;
      r_udf   <= w_udf_nxt;
    end
  end

  // Return-address storage, written at the current stack pointer on CALL.
  always_ff @(posedge clk) begin
    // NOTE: the stack array is deliberately not reset; entries are only
    // meaningful once pushed, and leaving it unreset lets it map to RAM.
    if (w_push) begin
      r_mem[r_sp] <= r_pc;
    end
  end

  assign bus.pc              = r_pc;
  assign bus.flush           = r_flush;
  assign bus.stack_level     = r_level;
  assign bus.stack_overflow  = r_ovf;
  assign bus.stack_underflow = r_udf;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed vector table, reset and
// coincidence sequences, then randomized traffic against a behavioural model.
module tb_pc_stack_unit;

  localparam int PCW   = 11;
  localparam int DEPTH = 2;
  localparam int PMASK = (1 << PCW) - 1;
  localparam logic [PCW-1:0] RVEC = 11'h7FF;

  logic clk;
  logic rst_n;

  pc_stack_if #(.PC_WIDTH(PCW), .STACK_DEPTH(DEPTH)) bus ();

  pc_stack_unit #(
    .PC_WIDTH(PCW), .STACK_DEPTH(DEPTH), .RESET_VEC(RVEC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         q1;
    bit         cv;
    logic [2:0] cmd;
    logic [8:0] imm;
    logic [1:0] page;
    logic [7:0] pcl;
    bit         clr;
    logic [10:0] e_pc;
    bit         e_flush;
    int         e_lvl;
    bit         e_ovf;
    bit         e_udf;
  } vec_t;

  function automatic vec_t mk(bit q1, bit cv, int cmd, int imm, int page,
                              int pcl, bit clr, int e_pc, bit e_flush,
                              int e_lvl, bit e_ovf, bit e_udf);
    vec_t v;
    v.q1 = q1; v.cv = cv; v.cmd = 3'(cmd); v.imm = 9'(imm);
    v.page = 2'(page); v.pcl = 8'(pcl); v.clr = clr;
    v.e_pc = 11'(e_pc); v.e_flush = e_flush; v.e_lvl = e_lvl;
    v.e_ovf = e_ovf; v.e_udf = e_udf;
    return v;
  endfunction

  task automatic drive(input bit q1, input bit cv, input logic [2:0] cmd,
                       input logic [8:0] imm, input logic [1:0] page,
                       input logic [7:0] pcl, input bit clr);
    bus.q1_en = q1; bus.cmd_valid = cv; bus.cmd = cmd; bus.imm = imm;
    bus.page_sel = page; bus.pcl_data = pcl; bus.clear_err = clr;
  endtask

  task automatic do_reset();
    drive(0, 0, 3'd0, 9'd0, 2'd0, 8'd0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_all(input string tag, input int e_pc, input bit e_fl,
                           input int e_lvl, input bit e_ovf, input bit e_udf,
                           input bit pc_known);
    if (pc_known) check({tag, ".pc"}, 32'(bus.pc), e_pc);
    check({tag, ".flush"}, 32'(bus.flush), 32'(e_fl));
    check({tag, ".level"}, 32'(bus.stack_level), e_lvl);
    check({tag, ".ovf"},   32'(bus.stack_overflow), 32'(e_ovf));
    check({tag, ".udf"},   32'(bus.stack_underflow), 32'(e_udf));
  endtask

  // Behavioural reference: stack as an array addressed by an integer
  // pointer taken modulo DEPTH, with per-entry "ever written" knowledge.
  int m_pc, m_sp, m_level;
  bit m_known, m_hold, m_flush, m_ovf, m_udf;
  int m_mem   [DEPTH];
  bit m_valid [DEPTH];

  task automatic model_reset();
    m_pc = int'(RVEC); m_known = 1; m_sp = 0; m_level = 0;
    m_hold = 0; m_flush = 0; m_ovf = 0; m_udf = 0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
  endtask

  task automatic model_step(input bit q1, input bit cv, input int cmd,
                            input int imm, input int page, input int pcl,
                            input bit clr);
    bit new_ovf = 0, new_udf = 0;
    if (cv && cmd >= 1 && cmd <= 5) begin
      case (cmd)
        1: begin m_pc = page * 512 + imm; m_known = 1; m_hold = 1; m_flush = 1; end
        2: begin
          m_mem[m_sp] = m_pc; m_valid[m_sp] = m_known;
          m_sp = (m_sp + 1) % DEPTH;
          m_pc = page * 512 + (imm % 256); m_known = 1;
          m_hold = 1; m_flush = 1;
          if (m_level == DEPTH) new_ovf = 1; else m_level++;
        end
        3: begin
          m_sp = (m_sp + DEPTH - 1) % DEPTH;
          m_pc = m_mem[m_sp]; m_known = m_valid[m_sp];
          m_hold = 1; m_flush = 1;
          if (m_level == 0) new_udf = 1; else m_level--;
        end
        4: m_flush = 1;
        default: begin m_pc = page * 512 + pcl; m_known = 1; m_hold = 1; m_flush = 1; end
      endcase
    end else if (q1) begin
      if (!m_hold) m_pc = (m_pc + 1) & PMASK;
      m_hold = 0; m_flush = 0;
    end
    m_ovf = (m_ovf && !clr) || new_ovf;
    m_udf = (m_udf && !clr) || new_udf;
  endtask

  vec_t tbl [37];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //        q1 cv cmd imm    pg pcl   clr  e_pc  fl lvl ovf udf
    tbl[0]  = mk(1,0,0,0,     0,0,    0, 'h000,0,0,0,0);
    tbl[1]  = mk(0,1,1,'h1A5, 1,0,    0, 'h3A5,1,0,0,0);
    tbl[2]  = mk(1,0,0,0,     0,0,    0, 'h3A5,0,0,0,0);
    tbl[3]  = mk(1,0,0,0,     0,0,    0, 'h3A6,0,0,0,0);
    tbl[4]  = mk(0,1,1,'h123, 0,0,    0, 'h123,1,0,0,0);
    tbl[5]  = mk(1,0,0,0,     0,0,    0, 'h123,0,0,0,0);
    tbl[6]  = mk(0,1,2,'h140, 0,0,    0, 'h040,1,1,0,0);
    tbl[7]  = mk(0,1,3,0,     0,0,    0, 'h123,1,0,0,0);
    tbl[8]  = mk(1,0,0,0,     0,0,    0, 'h123,0,0,0,0);
    tbl[9]  = mk(0,1,1,'h010, 0,0,    0, 'h010,1,0,0,0);
    tbl[10] = mk(0,1,2,'h0A0, 0,0,    0, 'h0A0,1,1,0,0);
    tbl[11] = mk(0,1,1,'h020, 0,0,    0, 'h020,1,1,0,0);
    tbl[12] = mk(0,1,2,'h0B0, 0,0,    0, 'h0B0,1,2,0,0);
    tbl[13] = mk(0,1,1,'h030, 0,0,    0, 'h030,1,2,0,0);
    tbl[14] = mk(0,1,2,'h0C0, 0,0,    0, 'h0C0,1,2,1,0);
    tbl[15] = mk(0,1,3,0,     0,0,    0, 'h030,1,1,1,0);
    tbl[16] = mk(0,1,3,0,     0,0,    0, 'h020,1,0,1,0);
    tbl[17] = mk(0,1,3,0,     0,0,    0, 'h030,1,0,1,1);
    tbl[18] = mk(0,0,0,0,     0,0,    1, 'h030,1,0,0,0);
    tbl[19] = mk(0,1,1,'h055, 0,0,    0, 'h055,1,0,0,0);
    tbl[20] = mk(1,0,0,0,     0,0,    0, 'h055,0,0,0,0);
    tbl[21] = mk(0,1,4,0,     0,0,    0, 'h055,1,0,0,0);
    tbl[22] = mk(1,0,0,0,     0,0,    0, 'h056,0,0,0,0);
    tbl[23] = mk(0,1,5,0,     2,'h80, 0, 'h480,1,0,0,0);
    tbl[24] = mk(1,0,0,0,     0,0,    0, 'h480,0,0,0,0);
    tbl[25] = mk(1,0,0,0,     0,0,    0, 'h481,0,0,0,0);
    tbl[26] = mk(1,1,2,'h011, 0,0,    0, 'h011,1,1,0,0);
    tbl[27] = mk(1,1,2,'h022, 0,0,    1, 'h022,1,2,0,0);
    tbl[28] = mk(1,1,2,'h033, 0,0,    1, 'h033,1,2,1,0);
    tbl[29] = mk(1,0,0,0,     0,0,    0, 'h033,0,2,1,0);
    tbl[30] = mk(0,0,0,0,     0,0,    1, 'h033,0,2,0,0);
    tbl[31] = mk(0,1,1,'h1FF, 3,0,    0, 'h7FF,1,2,0,0);
    tbl[32] = mk(1,0,0,0,     0,0,    0, 'h7FF,0,2,0,0);
    tbl[33] = mk(1,0,0,0,     0,0,    0, 'h000,0,2,0,0);
    tbl[34] = mk(0,1,6,'h0AA, 0,0,    0, 'h000,0,2,0,0);
    tbl[35] = mk(1,1,7,'h0AA, 0,0,    0, 'h001,0,2,0,0);
    tbl[36] = mk(0,0,0,0,     0,0,    0, 'h001,0,2,0,0);

    do_reset();
    check_all("reset", 'h7FF, 0, 0, 0, 0, 1);

    for (int i = 0; i < 37; i++) begin
      drive(tbl[i].q1, tbl[i].cv, tbl[i].cmd, tbl[i].imm, tbl[i].page,
            tbl[i].pcl, tbl[i].clr);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), int'(tbl[i].e_pc), tbl[i].e_flush,
                tbl[i].e_lvl, tbl[i].e_ovf, tbl[i].e_udf, 1);
    end

    // Reset asserted mid-cycle while a CALL is pending: state clears at once.
    drive(0, 1, 3'd2, 9'h044, 2'd1, 8'd0, 0);
    #3 rst_n = 1'b0;
    #1 check_all("rst_async", 'h7FF, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1 check_all("rst_hold", 'h7FF, 0, 0, 0, 0, 1);
    drive(0, 0, 3'd0, 9'd0, 2'd0, 8'd0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_all("rst_idle", 'h7FF, 0, 0, 0, 0, 1);
    drive(1, 0, 3'd0, 9'd0, 2'd0, 8'd0, 0);
    @(posedge clk);
    #1 check_all("rst_wrap", 'h000, 0, 0, 0, 0, 1);

    // Randomized traffic against the behavioural model.
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bit q1, cv, clr;
      int cmd, imm, page, pcl;
      q1   = ($urandom_range(0, 1) == 1);
      cv   = ($urandom_range(0, 9) < 4);
      cmd  = $urandom_range(0, 7);
      imm  = $urandom_range(0, 511);
      page = $urandom_range(0, 3);
      pcl  = $urandom_range(0, 255);
      clr  = ($urandom_range(0, 9) == 0);
      drive(q1, cv, 3'(cmd), 9'(imm), 2'(page), 8'(pcl), clr);
      model_step(q1, cv, cmd, imm, page, pcl, clr);
      @(posedge clk);
      #1;
      check_all($sformatf("rnd%0d", n), m_pc, m_flush, m_level, m_ovf,
                m_udf, m_known);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter and hardware return stack for the PIC16C5x-class core. It replaces the fixed 9-bit PC with a paged PC of configurable width and an N-deep circular call stack with level and error reporting. It sits between the execute sequencer, which issues decoded control commands, and the instruction fetch path, which consumes `pc` and `flush`. The PCL-write path here is a true jump: it suppresses the next increment instead of landing one word past the target.

## Interface
- `PC_WIDTH`, 11: PC bits, ≥10; page bits `PAGE_BITS = PC_WIDTH-9` (localparam)
- `STACK_DEPTH`, 2: return-stack entries, ≥2, any integer (no power-of-two requirement)
- `RESET_VEC`, 0: PC value loaded on reset

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `q1_en`  in  1  fetch Q1 strobe, one pulse per instruction cycle
- `cmd_valid`  in  1  execute command strobe (Q4)
- `cmd`  in  3  0 NONE, 1 GOTO, 2 CALL, 3 RETLW, 4 SKIP, 5 PCL_WR, 6–7 reserved (treated as NONE)
- `imm`  in  9  instruction literal field
- `page_sel`  in  PAGE_BITS  STATUS page-select bits
- `pcl_data`  in  8  data written to PCL
- `clear_err`  in  1  clears sticky error flags
- `pc`  out  PC_WIDTH  current program counter
- `flush`  out  1  next fetched instruction is to be discarded (NOP)
- `stack_level`  out  $clog2(STACK_DEPTH+1)  valid entries, saturating
- `stack_overflow`  out  1  sticky: push while full
- `stack_underflow`  out  1  sticky: pop while empty

## Operation
- Internal state: `pc`, `flush`, `hold`, `sp` (0..STACK_DEPTH-1), `level`, `mem[STACK_DEPTH]`, error flags.
- `q1_en` with no command: if `hold`, PC is unchanged; else `pc <= pc+1` modulo 2^PC_WIDTH. `hold` and `flush` are cleared.
- GOTO: `pc <= {page_sel, imm[8:0]}`; set `hold` and `flush`.
- CALL: `mem[sp] <= pc`; `sp <= (sp+1) mod DEPTH`; `pc <= {page_sel, 1'b0, imm[7:0]}`; set `hold` and `flush`. If `level==DEPTH`, set `stack_overflow` and keep `level`; otherwise increment `level`. A full-stack push overwrites the oldest entry (circular).
- RETLW: `sp <= (sp-1) mod DEPTH`; `pc <= mem[(sp-1) mod DEPTH]`; set `hold` and `flush`. If `level==0`, set `stack_underflow`, keep `level`=0, and still load the wrapped entry. Otherwise decrement `level`.
- SKIP: set `flush` only. PC increments normally, so the following instruction is discarded.
- PCL_WR: `pc <= {page_sel, 1'b0, pcl_data}`; set `hold` and `flush`.
- Command and `q1_en` in the same cycle: the command wins for `pc`, `sp`, `level`, `hold`, and `flush`. The `q1_en` clear is ignored.
- `clear_err` in the same cycle as a new error: the error wins (the flag stays set).
- Stack contents are not cleared by reset. Reads before any write are don't-care.

## Timing
- All outputs are registered. A command issued at edge N is visible at N+1.
- Reset (async assert, sync-released use): `pc=RESET_VEC`, `flush=0`, `hold=0`, `sp=0`, `level=0`, both error flags 0.
- Reset asserted mid-command: the command is lost and all state takes reset values immediately.
- Jump sequence: GOTO/CALL/RETLW/PCL_WR at Q4 → PC = target; next `q1_en` → no increment, flush clears; following `q1_en` → target+1.
- Skip sequence: SKIP at Q4 → `flush=1`; next `q1_en` → pc+1, flush clears.
- PC wrap: all-ones + 1 → 0, no flag.

## Test plan
- Reset with `PC_WIDTH=11`, `RESET_VEC=11'h7FF` → `pc=7FF`; first `q1_en` → `pc=000`, `flush=0`, `level=0`.
- `page_sel=2'b01`, GOTO `imm=9'h1A5` → `pc=3A5`, `flush=1`; next `q1_en` → `pc=3A5`, `flush=0`; next → `3A6`.
- `pc=0x123`, CALL `imm=9'h140`, `page_sel=0` → `pc=040`, `level=1`; RETLW → `pc=123`, `level=0`, no error flags.
- `DEPTH=2`: three CALLs from 0x010, 0x020, 0x030 → `overflow=1`, `level=2`; three RETLWs → 0x030, 0x020, then 0x030 (wrap), `underflow=1`.
- SKIP at `pc=0x055` → `flush=1`; `q1_en` → `pc=056`, `flush=0`. PCL_WR `0x80` with `page_sel=2'b10` → `pc=480`, held one Q1.
- Command and `q1_en` coincident, plus `clear_err` with a new overflow → command target is loaded without increment and `overflow` remains 1.
